// File: rtl/wb_timeout_bridge_pkg.sv
// Shared types and constants for the Wishbone timeout bridge and its status block.
package wb_timeout_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [2:0]  STAT_OFS         = 3'd0;
  localparam logic [2:0]  LADDR_OFS        = 3'd4;
  localparam logic [31:0] DEF_TIMEOUT_DATA = 32'hBADC_0FFE;
  localparam logic [7:0]  COUNT_MAX        = 8'hFF;

endpackage

// File: rtl/wb_timeout_status.sv
// Local status block: sticky timeout flag, saturating timeout count, last faulting
// address, plus the address decode and read mux for the 8-byte status window.
module wb_timeout_status
  import wb_timeout_bridge_pkg::*;
#(
  parameter logic [31:0] STATUS_ADDR = 32'h300F_FFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:2] adr_i,
  input  logic        access_i,
  input  logic        we_i,
  input  logic        clr_bit_i,
  input  logic        timeout_i,
  input  logic [31:0] fault_adr_i,
  output logic        hit_o,
  output logic [31:0] rdata_o,
  output logic        flag_o
);

  logic        flag_q, flag_d;
  logic [7:0]  count_q, count_d;
  logic [31:0] last_addr_q, last_addr_d;
  logic        clear;

  assign hit_o  = (adr_i[31:3] == STATUS_ADDR[31:3]);
  assign clear  = access_i && we_i && clr_bit_i && (adr_i[2] == STAT_OFS[2]);
  assign flag_o = flag_q;

  // A clear and a timeout are mutually exclusive: the FSM cannot be in FWD while
  // it is serving a local access.
  always_comb begin
    flag_d      = flag_q;
    count_d     = count_q;
    last_addr_d = last_addr_q;
    if (clear) begin
      flag_d  = 1'b0;
      count_d = '0;
    end else if (timeout_i) begin
      flag_d      = 1'b1;
      count_d     = (count_q == COUNT_MAX) ? COUNT_MAX : count_q + 8'd1;
      last_addr_d = fault_adr_i;
    end
  end

  always_comb begin
    if (adr_i[2] == LADDR_OFS[2]) rdata_o = last_addr_q;
    else                          rdata_o = {16'b0, count_q, 7'b0, flag_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q      <= 1'b0;
      count_q     <= '0;
      last_addr_q <= '0;
    end else begin
      flag_q      <= flag_d;
      count_q     <= count_d;
      last_addr_q <= last_addr_d;
    end
  end

endmodule

// File: rtl/wb_timeout_bridge.sv
// Registered Wishbone classic bridge that forwards to the user-project splitter and
// aborts any transaction the slave leaves unanswered for TIMEOUT_CYCLES.
module wb_timeout_bridge
  import wb_timeout_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = DEF_TIMEOUT_DATA,
  parameter logic [31:0] STATUS_ADDR    = 32'h300F_FFF0
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        m_wb_cyc_i,
  input  logic        m_wb_stb_i,
  input  logic        m_wb_we_i,
  input  logic [3:0]  m_wb_sel_i,
  input  logic [31:0] m_wb_adr_i,
  input  logic [31:0] m_wb_dat_i,
  output logic        m_wb_ack_o,
  output logic [31:0] m_wb_dat_o,
  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_we_o,
  output logic [3:0]  s_wb_sel_o,
  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_o,
  input  logic        s_wb_ack_i,
  input  logic [31:0] s_wb_dat_i,
  output logic        timeout_irq_o
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        s_cyc_q, s_cyc_d;
  logic        s_stb_q, s_stb_d;
  logic        s_we_q, s_we_d;
  logic [3:0]  s_sel_q, s_sel_d;
  logic [31:0] s_adr_q, s_adr_d;
  logic [31:0] s_dat_q, s_dat_d;
  logic        m_ack_q, m_ack_d;
  logic [31:0] m_dat_q, m_dat_d;

  logic        local_hit;
  logic [31:0] local_rdata;
  logic        local_access;
  logic        timeout_evt;
  logic        flag;

  wb_timeout_status #(
    .STATUS_ADDR(STATUS_ADDR)
  ) u_status (
    .clk        (wb_clk_i),
    .rst_n      (rst_n),
    .adr_i      (m_wb_adr_i[31:2]),
    .access_i   (local_access),
    .we_i       (m_wb_we_i),
    .clr_bit_i  (m_wb_sel_i[0] & m_wb_dat_i[0]),
    .timeout_i  (timeout_evt),
    .fault_adr_i(s_adr_q),
    .hit_o      (local_hit),
    .rdata_o    (local_rdata),
    .flag_o     (flag)
  );

  // IDLE ignores the request during the ack cycle, because a classic master still
  // holds stb on the edge where it samples the ack.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    s_cyc_d      = s_cyc_q;
    s_stb_d      = s_stb_q;
    s_we_d       = s_we_q;
    s_sel_d      = s_sel_q;
    s_adr_d      = s_adr_q;
    s_dat_d      = s_dat_q;
    m_ack_d      = 1'b0;
    m_dat_d      = m_dat_q;
    local_access = 1'b0;
    timeout_evt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m_wb_cyc_i && m_wb_stb_i && !m_ack_q) begin
          if (local_hit) begin
            local_access = 1'b1;
            m_dat_d      = m_wb_we_i ? 32'h0 : local_rdata;
            state_d      = ST_RESP;
          end else begin
            s_cyc_d = 1'b1;
            s_stb_d = 1'b1;
            s_we_d  = m_wb_we_i;
            s_sel_d = m_wb_sel_i;
            s_adr_d = m_wb_adr_i;
            s_dat_d = m_wb_dat_i;
            timer_d = '0;
            state_d = ST_FWD;
          end
        end
      end
      ST_FWD: begin
        if (!m_wb_cyc_i) begin
          s_cyc_d = 1'b0;
          s_stb_d = 1'b0;
          state_d = ST_IDLE;
        end else if (s_wb_ack_i) begin
          s_cyc_d = 1'b0;
          s_stb_d = 1'b0;
          m_dat_d = s_wb_dat_i;
          state_d = ST_RESP;
        end else if (timer_q == TIMER_LAST) begin
          s_cyc_d     = 1'b0;
          s_stb_d     = 1'b0;
          m_dat_d     = TIMEOUT_DATA;
          timeout_evt = 1'b1;
          state_d     = ST_RESP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_RESP: begin
        m_ack_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      s_cyc_q <= 1'b0;
      s_stb_q <= 1'b0;
      s_we_q  <= 1'b0;
      s_sel_q <= '0;
      s_adr_q <= '0;
      s_dat_q <= '0;
      m_ack_q <= 1'b0;
      m_dat_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      s_cyc_q <= s_cyc_d;
      s_stb_q <= s_stb_d;
      s_we_q  <= s_we_d;
      s_sel_q <= s_sel_d;
      s_adr_q <= s_adr_d;
      s_dat_q <= s_dat_d;
      m_ack_q <= m_ack_d;
      m_dat_q <= m_dat_d;
    end
  end

  assign m_wb_ack_o    = m_ack_q;
  assign m_wb_dat_o    = m_dat_q;
  assign s_wb_cyc_o    = s_cyc_q;
  assign s_wb_stb_o    = s_stb_q;
  assign s_wb_we_o     = s_we_q;
  assign s_wb_sel_o    = s_sel_q;
  assign s_wb_adr_o    = s_adr_q;
  assign s_wb_dat_o    = s_dat_q;
  assign timeout_irq_o = flag;

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Scoreboard bench for wb_timeout_bridge: a transaction-level model predicts each
// response and a negedge monitor compares every ack the bridge produces.
module tb_wb_timeout_bridge;

  localparam int          TO      = 16;
  localparam logic [31:0] TO_DATA = 32'hBADC_0FFE;
  localparam logic [31:0] STAT    = 32'h300F_FFF0;
  localparam int          NEVER   = 1000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        mCyc = 1'b0, mStb = 1'b0, mWe = 1'b0;
  logic [3:0]  mSel = 4'hF;
  logic [31:0] mAdr = '0, mDat = '0;
  logic        mAck;
  logic [31:0] mDatO;
  logic        sCyc, sStb, sWe;
  logic [3:0]  sSel;
  logic [31:0] sAdr, sDatO;
  logic        sAck;
  logic [31:0] sDatI;
  logic        irq;

  always #5 clk = ~clk;

  wb_timeout_bridge #(
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_DATA  (TO_DATA),
    .STATUS_ADDR   (STAT)
  ) dut (
    .wb_clk_i     (clk),
    .rst_n        (rst_n),
    .m_wb_cyc_i   (mCyc),
    .m_wb_stb_i   (mStb),
    .m_wb_we_i    (mWe),
    .m_wb_sel_i   (mSel),
    .m_wb_adr_i   (mAdr),
    .m_wb_dat_i   (mDat),
    .m_wb_ack_o   (mAck),
    .m_wb_dat_o   (mDatO),
    .s_wb_cyc_o   (sCyc),
    .s_wb_stb_o   (sStb),
    .s_wb_we_o    (sWe),
    .s_wb_sel_o   (sSel),
    .s_wb_adr_o   (sAdr),
    .s_wb_dat_o   (sDatO),
    .s_wb_ack_i   (sAck),
    .s_wb_dat_i   (sDatI),
    .timeout_irq_o(irq)
  );

  int total = 0;
  int bad   = 0;

  // Slave model: acks combinationally on stb cycle number ackAt (0-based).
  int          ackAt     = NEVER;
  int          stbCnt    = 0;
  logic        lateAck   = 1'b0;
  logic [31:0] slaveData = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) stbCnt <= 0;
    else        stbCnt <= sStb ? stbCnt + 1 : 0;
  end
  assign sAck  = (sStb && (stbCnt == ackAt)) || lateAck;
  assign sDatI = slaveData;

  // Reference model of the status block and the scoreboard of expected acks.
  typedef struct packed {
    logic [31:0] data;
    logic        irq;
  } exp_t;
  exp_t        sb[$];
  logic        modFlag  = 1'b0;
  int          modCount = 0;
  logic [31:0] modLast  = '0;
  logic [31:0] lastResp = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mAck) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_ack: got ack with data %h, expected no ack", mDatO);
      end else begin
        e = sb.pop_front();
        checkOutput("ack_data", mDatO, e.data);
        checkOutput("ack_irq", {31'b0, irq}, {31'b0, e.irq});
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input int ack, input logic [31:0] sdata);
    exp_t e;
    int   lat, stbs, expLat, expStb;
    logic isLocal;
    isLocal = (adr[31:3] == STAT[31:3]);
    if (isLocal) begin
      e.data = we ? 32'h0 : (adr[2] ? modLast : {16'b0, modCount[7:0], 7'b0, modFlag});
      if (we && sel[0] && dat[0] && !adr[2]) begin
        modFlag  = 1'b0;
        modCount = 0;
      end
      expLat = 1;
      expStb = 0;
    end else if (ack < TO) begin
      e.data = sdata;
      expLat = ack + 2;
      expStb = ack + 1;
    end else begin
      e.data  = TO_DATA;
      modFlag = 1'b1;
      if (modCount < 255) modCount++;
      modLast = adr;
      expLat  = TO + 1;
      expStb  = TO;
    end
    e.irq = modFlag;
    sb.push_back(e);
    ackAt     = ack;
    slaveData = sdata;
    @(negedge clk);
    mCyc = 1'b1; mStb = 1'b1; mWe = we; mAdr = adr; mDat = dat; mSel = sel;
    lat  = 0;
    stbs = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (sStb) stbs++;
    end while (!mAck && lat < 100);
    mCyc = 1'b0; mStb = 1'b0; mWe = 1'b0;
    if (!mAck) begin
      total++;
      bad++;
      $display("[TB] FAIL ack_wait: no ack within 100 cycles for adr %h", adr);
      void'(sb.pop_back());
    end
    checkOutput("ack_latency", 32'(lat - 1), 32'(expLat));
    checkOutput("stb_cycles", 32'(stbs), 32'(expStb));
    lastResp = e.data;
    ackAt    = NEVER;
    @(posedge clk); #1;
  endtask

  task automatic applyAbort(input logic [31:0] adr);
    ackAt = NEVER;
    @(negedge clk);
    mCyc = 1'b1; mStb = 1'b1; mWe = 1'b0; mAdr = adr; mSel = 4'hF;
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("abort_scyc_before", {31'b0, sCyc}, 32'd1);
    mCyc = 1'b0; mStb = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_scyc_after", {31'b0, sCyc}, 32'd0);
    checkOutput("abort_sstb_after", {31'b0, sStb}, 32'd0);
    lateAck = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      checkOutput("late_ack_no_mack", {31'b0, mAck}, 32'd0);
    end
    lateAck = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("abort_hold_data", mDatO, lastResp);
    checkOutput("abort_irq", {31'b0, irq}, {31'b0, modFlag});
  endtask

  task automatic applyResetMidFwd(input logic [31:0] adr);
    ackAt = NEVER;
    @(negedge clk);
    mCyc = 1'b1; mStb = 1'b1; mWe = 1'b1; mAdr = adr; mDat = 32'hA5A5_5A5A; mSel = 4'hF;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("rst_fwd_stb_before", {31'b0, sStb}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mack", {31'b0, mAck}, 32'd0);
    checkOutput("rst_mdat", mDatO, 32'd0);
    checkOutput("rst_ctl", {28'b0, sCyc, sStb, sWe, irq}, 32'd0);
    checkOutput("rst_ssel", {28'b0, sSel}, 32'd0);
    checkOutput("rst_sadr", sAdr, 32'd0);
    checkOutput("rst_sdat", sDatO, 32'd0);
    mCyc = 1'b0; mStb = 1'b0; mWe = 1'b0;
    modFlag  = 1'b0;
    modCount = 0;
    modLast  = '0;
    lastResp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] adr;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_ctl", {27'b0, mAck, sCyc, sStb, sWe, irq}, 32'd0);
    checkOutput("reset_mdat", mDatO, 32'd0);
    checkOutput("reset_sadr", sAdr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(1'b0, STAT,          32'h0, 4'hF, NEVER, 32'h0);
    applyStimulus(1'b0, STAT + 32'd4,  32'h0, 4'hF, NEVER, 32'h0);
    applyStimulus(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 32'h1234_5678);
    applyStimulus(1'b1, 32'h3000_0040, 32'hCAFE_F00D, 4'h3, 3, 32'h0BAD_BEEF);
    applyStimulus(1'b0, 32'h3000_0080, 32'h0, 4'hF, TO - 1, 32'h5566_7788);
    applyStimulus(1'b0, 32'h3000_0100, 32'h0, 4'hF, NEVER, 32'h0);
    applyStimulus(1'b0, STAT,          32'h0, 4'hF, NEVER, 32'h0);
    applyStimulus(1'b0, STAT + 32'd4,  32'h0, 4'hF, NEVER, 32'h0);
    applyStimulus(1'b1, STAT + 32'd4,  32'hFFFF_FFFF, 4'hF, NEVER, 32'h0);
    applyStimulus(1'b0, STAT + 32'd4,  32'h0, 4'hF, NEVER, 32'h0);
    applyAbort(32'h3000_0200);
    applyStimulus(1'b1, STAT,          32'h1, 4'h1, NEVER, 32'h0);
    checkOutput("irq_after_clear", {31'b0, irq}, 32'd0);
    applyStimulus(1'b0, STAT,          32'h0, 4'hF, NEVER, 32'h0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        adr = STAT | (32'($urandom_range(0, 1)) << 2);
      end else begin
        adr = $urandom & 32'hFFFF_FFFC;
        if (adr[31:3] == STAT[31:3]) adr[31] = ~adr[31];
      end
      applyStimulus(1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, TO + 2)), $urandom);
    end

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 32'h3000_1000 + 32'(i * 4), 32'h0, 4'hF, NEVER, 32'h0);
    end
    applyStimulus(1'b0, STAT,         32'h0, 4'hF, NEVER, 32'h0);
    applyStimulus(1'b0, STAT + 32'd4, 32'h0, 4'hF, NEVER, 32'h0);

    applyResetMidFwd(32'h3000_2000);
    applyStimulus(1'b0, 32'h3000_2004, 32'h0, 4'hF, 2, 32'h7777_0001);
    applyStimulus(1'b0, STAT,          32'h0, 4'hF, NEVER, 32'h0);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
